tinyriscv_core_lite: RTL and testbench

- Single-cycle RV32I integer core with a private unified instruction/data memory and a 32x32 register file.
- Intended as the simulation top of the tinyriscv flow.
- Programs are preloaded as 32-bit hex words into the memory array.
- Pass/fail is signalled by software through x26 (done flag), x27 (pass flag) and x3 (test number).
- JTAG pins are present for pin compatibility; debug logic is out of scope.

---
 rtl/tinyriscv_pkg.sv | 22 ++
 rtl/tinyriscv_if.sv | 15 +
 rtl/tinyriscv_regs.sv | 25 ++
 rtl/tinyriscv_sim_ram.sv | 16 +
 rtl/tinyriscv_core_lite.sv | 113 +++++++++++
 tb/tb_tinyriscv_core_lite.sv | 206 ++++++++++++++++++++
 6 files changed

// File: rtl/tinyriscv_pkg.sv
// tinyriscv_pkg: opcodes, funct3 codes, bus width and reset level shared by the tinyriscv core.
package tinyriscv_pkg;
  localparam int XLEN = 32;
  localparam logic RST_ACTIVE = 1'b1;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_OP     = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_e;
  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR = 3'd5, F3_OR = 3'd6, F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
endpackage

// File: rtl/tinyriscv_if.sv
// tinyriscv_if: word-addressed instruction fetch and byte-enabled data bus between core and RAM.
interface tinyriscv_if
  import tinyriscv_pkg::*;
#(
  parameter int AW = 12
);
  logic [AW-1:0] iaddr;
  logic [AW-1:0] daddr;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] rdata;
  logic [XLEN-1:0] wdata;
  logic [3:0] be;
  modport master (output iaddr, daddr, wdata, be, input inst, rdata);
  modport slave (input iaddr, daddr, wdata, be, output inst, rdata);
endinterface

// File: rtl/tinyriscv_regs.sv
// tinyriscv_regs: 32x32 register file, two async read ports, one sync write port, x0 hardwired to 0.
module tinyriscv_regs
  import tinyriscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_raddr1,
  input  logic [4:0]      i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);
  logic [XLEN-1:0] regs [0:31];
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_we && i_waddr != 5'd0) begin
      regs[i_waddr] <= i_wdata;
    end
  end
  assign o_rdata1 = i_raddr1 == 5'd0 ? '0 : regs[i_raddr1];
  assign o_rdata2 = i_raddr2 == 5'd0 ? '0 : regs[i_raddr2];
endmodule

// File: rtl/tinyriscv_sim_ram.sv
// tinyriscv_sim_ram: unified program/data memory, async reads, byte-enabled sync write; never reset.
module tinyriscv_sim_ram
  import tinyriscv_pkg::*;
#(
  parameter int MEM_DEPTH = 4096
) (
  input logic        clk,
  tinyriscv_if.slave bus
);
  logic [XLEN-1:0] rom [0:MEM_DEPTH-1];
  assign bus.inst  = rom[bus.iaddr];
  assign bus.rdata = rom[bus.daddr];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (bus.be[i]) rom[bus.daddr][8*i+:8] <= bus.wdata[8*i+:8];
  end
endmodule

// File: rtl/tinyriscv_core_lite.sv
// tinyriscv_core_lite: single-cycle RV32I core with private RAM; define TINYRISCV_MUL_EN to add MUL.
module tinyriscv_core_lite
  import tinyriscv_pkg::*;
#(
  parameter int              MEM_DEPTH = 4096,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic jtag_TCK,
  input  logic jtag_TMS,
  input  logic jtag_TDI,
  output logic jtag_TDO
);
  localparam int AW = $clog2(MEM_DEPTH);
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_inst, w_rs1, w_rs2, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_alu_b, w_alu, w_sra, w_addr, w_load, w_mul, w_wd, w_npc, w_pc4;
  logic [6:0]      w_op, w_f7;
  logic [4:0]      w_rd, w_ra1, w_ra2;
  logic [2:0]      w_f3;
  logic [15:0]     w_half;
  logic [7:0]      w_byte;
  logic [3:0]      w_be, w_st_be;
  logic            w_we, w_take, w_eq, w_lt, w_ltu, w_ld_ok, w_op_ok, w_mul_ok, w_run;
  tinyriscv_if #(.AW(AW)) bus ();
  assign jtag_TDO = 1'b0;
  assign w_run    = rst != RST_ACTIVE;
  assign bus.iaddr = r_pc[AW+1:2];
  assign w_inst  = bus.inst;
  assign w_op    = w_inst[6:0];
  assign w_rd    = w_inst[11:7];
  assign w_f3    = w_inst[14:12];
  assign w_ra1   = w_inst[19:15];
  assign w_ra2   = w_inst[24:20];
  assign w_f7    = w_inst[31:25];
  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'b0};
  assign w_imm_j = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  assign w_pc4   = r_pc + 32'd4;
  tinyriscv_regs u_regs (
    .clk(clk), .rst(rst), .i_we(w_we & w_run), .i_waddr(w_rd), .i_wdata(w_wd),
    .i_raddr1(w_ra1), .i_raddr2(w_ra2), .o_rdata1(w_rs1), .o_rdata2(w_rs2)
  );
  tinyriscv_sim_ram #(.MEM_DEPTH(MEM_DEPTH)) u_sim_ram (.clk(clk), .bus(bus));
  assign w_alu_b = w_op == OP_OP ? w_rs2 : w_imm_i;
  assign w_sra   = $signed(w_rs1) >>> w_alu_b[4:0];
  always_comb begin
    w_alu = '0;
    case (w_f3)
      F3_ADD:  w_alu = (w_op == OP_OP && w_f7[5]) ? w_rs1 - w_alu_b : w_rs1 + w_alu_b;
      F3_SLL:  w_alu = w_rs1 << w_alu_b[4:0];
      F3_SLT:  w_alu = {31'b0, $signed(w_rs1) < $signed(w_alu_b)};
      F3_SLTU: w_alu = {31'b0, w_rs1 < w_alu_b};
      F3_XOR:  w_alu = w_rs1 ^ w_alu_b;
      F3_SR:   w_alu = w_f7[5] ? w_sra : w_rs1 >> w_alu_b[4:0];
      F3_OR:   w_alu = w_rs1 | w_alu_b;
      default: w_alu = w_rs1 & w_alu_b;
    endcase
  end
  assign w_op_ok = w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && (w_f3 == F3_ADD || w_f3 == F3_SR));
`ifdef TINYRISCV_MUL_EN
  assign w_mul_ok = w_f7 == 7'b0000001 && w_f3 == F3_ADD;
  assign w_mul    = w_rs1 * w_rs2;
`else
  assign w_mul_ok = 1'b0;
  assign w_mul    = '0;
`endif
  assign w_eq   = w_rs1 == w_rs2;
  assign w_lt   = $signed(w_rs1) < $signed(w_rs2);
  assign w_ltu  = w_rs1 < w_rs2;
  assign w_take = w_f3 == F3_BEQ  ? w_eq  : w_f3 == F3_BNE  ? !w_eq  :
                  w_f3 == F3_BLT  ? w_lt  : w_f3 == F3_BGE  ? !w_lt  :
                  w_f3 == F3_BLTU ? w_ltu : w_f3 == F3_BGEU ? !w_ltu : 1'b0;
  // Loads and stores share one address adder; only the immediate format differs.
  assign w_addr    = w_rs1 + (w_op == OP_STORE ? w_imm_s : w_imm_i);
  assign bus.daddr = w_addr[AW+1:2];
  assign w_byte    = 8'(bus.rdata >> {w_addr[1:0], 3'b000});
  assign w_half    = w_addr[1] ? bus.rdata[31:16] : bus.rdata[15:0];
  assign w_ld_ok   = w_f3 == F3_B || w_f3 == F3_H || w_f3 == F3_W || w_f3 == F3_BU || w_f3 == F3_HU;
  assign w_load    = w_f3 == F3_B  ? {{24{w_byte[7]}}, w_byte} :
                     w_f3 == F3_H  ? {{16{w_half[15]}}, w_half} :
                     w_f3 == F3_BU ? {24'b0, w_byte} :
                     w_f3 == F3_HU ? {16'b0, w_half} : bus.rdata;
  assign w_st_be   = w_f3 == F3_B ? 4'b0001 << w_addr[1:0] :
                     w_f3 == F3_H ? (w_addr[1] ? 4'b1100 : 4'b0011) :
                     w_f3 == F3_W ? 4'b1111 : 4'b0000;
  assign bus.wdata = w_f3 == F3_B ? {4{w_rs2[7:0]}} : w_f3 == F3_H ? {2{w_rs2[15:0]}} : w_rs2;
  assign bus.be    = w_run ? w_be : 4'b0000;
  always_comb begin
    w_we  = 1'b0;
    w_wd  = w_alu;
    w_npc = w_pc4;
    w_be  = 4'b0000;
    case (w_op)
      OP_LUI:    begin w_we = 1'b1; w_wd = w_imm_u; end
      OP_AUIPC:  begin w_we = 1'b1; w_wd = r_pc + w_imm_u; end
      OP_JAL:    begin w_we = 1'b1; w_wd = w_pc4; w_npc = r_pc + w_imm_j; end
      OP_JALR:   begin w_we = 1'b1; w_wd = w_pc4; w_npc = (w_rs1 + w_imm_i) & ~32'd1; end
      OP_BRANCH: w_npc = w_take ? r_pc + w_imm_b : w_pc4;
      OP_LOAD:   begin w_we = w_ld_ok; w_wd = w_load; end
      OP_STORE:  w_be = w_st_be;
      OP_IMM:    w_we = 1'b1;
      OP_OP:     begin w_we = w_op_ok | w_mul_ok; w_wd = w_mul_ok ? w_mul : w_alu; end
      default:   w_we = 1'b0;
    endcase
  end
  always_ff @(posedge clk) r_pc <= w_run ? w_npc : RESET_PC;
  logic w_unused;
  assign w_unused = &{1'b0, jtag_TCK, jtag_TMS, jtag_TDI, w_addr[XLEN-1:AW+2]};
endmodule

// File: tb/tb_tinyriscv_core_lite.sv
// tb_tinyriscv_core_lite: directed programs preloaded into RAM; expected register/memory values queued and drained after each run.
module tb_tinyriscv_core_lite;
  import tinyriscv_pkg::*;
  logic clk = 1'b0, rst = 1'b1, tck = 1'b0, tms = 1'b0, tdi = 1'b0, tdo;
  int checks = 0, errors = 0;
  typedef struct {
    string tag;
    bit is_mem;
    logic [11:0] idx;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];
  tinyriscv_core_lite #(.MEM_DEPTH(4096), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .jtag_TCK(tck), .jtag_TMS(tms), .jtag_TDI(tdi), .jtag_TDO(tdo)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(OP_OP)};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:0], 7'(OP_STORE)};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'(OP_BRANCH)};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, int op);
    return {imm[19:0], 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'(OP_JAL)};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic put(input int addr, input logic [31:0] w);
    dut.u_sim_ram.rom[12'(addr >> 2)] = w;
  endtask
  task automatic clear_prog;
    for (int i = 0; i < 128; i++) dut.u_sim_ram.rom[12'(i)] = 32'h0000_0013;
  endtask
  task automatic exp_reg(input string tag, input int r, input logic [31:0] v);
    sb.push_back('{tag, 1'b0, 12'(r), v});
  endtask
  task automatic exp_mem(input string tag, input int word, input logic [31:0] v);
    sb.push_back('{tag, 1'b1, 12'(word), v});
  endtask
  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic run(input int n);
    exp_t e;
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.is_mem ? dut.u_sim_ram.rom[e.idx] : dut.u_regs.regs[e.idx[4:0]], e.exp);
    end
  endtask
  logic [31:0] acc;
  initial begin
    do_reset;
    clear_prog;
    put('h00, enc_i(-1, 0, F3_ADD, 1, OP_IMM));
    put('h04, enc_i(28, 1, F3_SR, 2, OP_IMM));
    put('h08, enc_i('h41C, 1, F3_SR, 3, OP_IMM));
    put('h0C, enc_r(0, 1, 0, F3_SLTU, 4));
    put('h10, enc_i(5, 0, F3_ADD, 0, OP_IMM));
    put('h14, enc_r(0, 2, 1, F3_ADD, 5));
    put('h18, enc_r('h20, 4, 0, F3_ADD, 6));
    put('h1C, enc_r(0, 2, 4, F3_SLL, 7));
    put('h20, enc_i('h0F0, 1, F3_XOR, 8, OP_IMM));
    put('h24, enc_j(0, 0));
    check("reset_pc", dut.r_pc, 32'h0);
    check("jtag_tdo", {31'b0, tdo}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_retire_x1", dut.u_regs.regs[1], 32'hFFFF_FFFF);
    check("first_retire_x2", dut.u_regs.regs[2], 32'h0);
    check("first_retire_pc", dut.r_pc, 32'h4);
    exp_reg("addi_x1", 1, 32'hFFFF_FFFF);
    exp_reg("srli_x2", 2, 32'h0000_000F);
    exp_reg("srai_x3", 3, 32'hFFFF_FFFF);
    exp_reg("sltu_x4", 4, 32'h1);
    exp_reg("x0_zero", 0, 32'h0);
    exp_reg("add_wrap_x5", 5, 32'h0000_000E);
    exp_reg("sub_x6", 6, 32'hFFFF_FFFF);
    exp_reg("sll_x7", 7, 32'h0000_8000);
    exp_reg("xori_x8", 8, 32'hFFFF_FF0F);
    run(20);
    do_reset;
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.u_regs.regs[5'(i)];
    check("reset_regs_or", acc, 32'h0);
    check("reset_pc2", dut.r_pc, 32'h0);
    clear_prog;
    dut.u_sim_ram.rom[12'h41] = 32'hDEAD_BEEF;
    put('h00, enc_s('h104, 0, 0, F3_W));
    put('h04, enc_i('h100, 0, F3_ADD, 10, OP_IMM));
    put('h08, enc_u('h80FF8, 11, OP_LUI));
    put('h0C, enc_i('hF01, 11, F3_ADD, 11, OP_IMM));
    put('h10, enc_s(0, 11, 10, F3_W));
    put('h14, enc_i(1, 10, F3_B, 12, OP_LOAD));
    put('h18, enc_i(1, 10, F3_BU, 13, OP_LOAD));
    put('h1C, enc_i(2, 10, F3_H, 14, OP_LOAD));
    put('h20, enc_i(2, 10, F3_HU, 15, OP_LOAD));
    put('h24, enc_i('h0AA, 0, F3_ADD, 16, OP_IMM));
    put('h28, enc_s(3, 16, 10, F3_B));
    put('h2C, enc_i(0, 10, F3_W, 17, OP_LOAD));
    put('h30, enc_i(2, 10, F3_W, 18, OP_LOAD));
    put('h34, enc_i('h100, 0, F3_ADD, 19, OP_IMM));
    put('h38, enc_i(0, 19, F3_W, 19, OP_LOAD));
    put('h3C, enc_s(7, 16, 10, F3_H));
    put('h40, enc_j(0, 0));
    do_reset;
    check("no_store_in_reset", dut.u_sim_ram.rom[12'h41], 32'hDEAD_BEEF);
    exp_reg("lb_x12", 12, 32'h0000_007F);
    exp_reg("lbu_x13", 13, 32'h0000_007F);
    exp_reg("lh_x14", 14, 32'hFFFF_80FF);
    exp_reg("lhu_x15", 15, 32'h0000_80FF);
    exp_reg("lw_after_sb_x17", 17, 32'hAAFF_7F01);
    exp_reg("lw_misaligned_x18", 18, 32'hAAFF_7F01);
    exp_reg("lw_rd_eq_rs1_x19", 19, 32'hAAFF_7F01);
    exp_mem("mem_0x100", 'h40, 32'hAAFF_7F01);
    exp_mem("mem_0x104_sh", 'h41, 32'h00AA_0000);
    run(30);
    do_reset;
    clear_prog;
    put('h00, enc_i(-1, 0, F3_ADD, 5, OP_IMM));
    put('h04, enc_i(1, 0, F3_ADD, 6, OP_IMM));
    put('h08, enc_b(8, 6, 5, F3_BLT));
    put('h0C, enc_i(7, 0, F3_ADD, 7, OP_IMM));
    put('h10, enc_b(8, 5, 6, F3_BGEU));
    put('h14, enc_i(8, 0, F3_ADD, 8, OP_IMM));
    put('h18, enc_i('h41, 0, F3_ADD, 9, OP_IMM));
    put('h20, enc_j('h10, 1));
    put('h24, enc_i(9, 0, F3_ADD, 7, OP_IMM));
    put('h30, enc_i(0, 9, 0, 2, OP_JALR));
    put('h34, enc_i('h33, 0, F3_ADD, 7, OP_IMM));
    put('h40, enc_i('h55, 0, F3_ADD, 10, OP_IMM));
    put('h44, enc_j(0, 0));
    do_reset;
    exp_reg("branch_skips_x7", 7, 32'h0);
    exp_reg("bgeu_not_taken_x8", 8, 32'h8);
    exp_reg("jal_link_x1", 1, 32'h24);
    exp_reg("jalr_link_x2", 2, 32'h34);
    exp_reg("jalr_target_x10", 10, 32'h55);
    run(30);
    check("loop_pc", dut.r_pc, 32'h44);
    do_reset;
    clear_prog;
    put('h00, enc_i(5, 0, F3_ADD, 3, OP_IMM));
    put('h04, enc_u('h10, 20, OP_LUI));
    put('h08, enc_u('h10, 21, OP_LUI));
    put('h0C, enc_i(1, 21, F3_ADD, 21, OP_IMM));
    put('h10, enc_i('h123, 0, F3_ADD, 22, OP_IMM));
    put('h14, enc_r(1, 21, 20, 0, 22));
    put('h18, 32'h0000_0073);
    put('h1C, enc_i('h300, 1, 1, 23, OP_SYSTEM));
    put('h20, 32'hFFFF_FFFF);
    put('h24, enc_r(1, 21, 20, 1, 24));
    put('h28, enc_i(1, 0, F3_ADD, 27, OP_IMM));
    put('h2C, enc_i(1, 0, F3_ADD, 26, OP_IMM));
    put('h30, enc_j(0, 0));
    do_reset;
`ifdef TINYRISCV_MUL_EN
    exp_reg("mul_x22", 22, 32'h0001_0000);
`else
    exp_reg("mul_disabled_x22", 22, 32'h0000_0123);
`endif
    exp_reg("csr_nop_x23", 23, 32'h0);
    exp_reg("mulh_nop_x24", 24, 32'h0);
    exp_reg("undef_nop_x31", 31, 32'h0);
    exp_reg("done_x26", 26, 32'h1);
    exp_reg("pass_x27", 27, 32'h1);
    exp_reg("testnum_x3", 3, 32'h5);
    run(30);
    check("nop_loop_pc", dut.r_pc, 32'h30);
    if (dut.u_regs.regs[26] == 32'h1 && dut.u_regs.regs[27] == 32'h1) $display("program signalled pass");
    do_reset;
    clear_prog;
    put('h00, enc_i(7, 0, F3_ADD, 3, OP_IMM));
    put('h04, enc_i(0, 0, F3_ADD, 27, OP_IMM));
    put('h08, enc_i(1, 0, F3_ADD, 26, OP_IMM));
    put('h0C, enc_j(0, 0));
    do_reset;
    exp_reg("variant_done_x26", 26, 32'h1);
    exp_reg("variant_pass_x27", 27, 32'h0);
    exp_reg("variant_testnum_x3", 3, 32'h7);
    run(20);
    if (dut.u_regs.regs[26] == 32'h1 && dut.u_regs.regs[27] == 32'h0)
      $display("program signalled test number %0d", dut.u_regs.regs[3]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
